// File: rtl/ysyx_22040750_cache_refill_pkg.sv
// Shared encodings for the cache refill engine: FSM states, AXI beat size, AR request view.
package ysyx_22040750_cache_refill_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int         BEAT_BYTES  = 8;
  localparam logic [2:0] AXI_SIZE_8B = 3'b011;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_req_t;
endpackage

// File: rtl/ysyx_22040750_refill_linebuf.sv
// Line buffer plus beat counter: writes beats into successive slots until the limit, then drops them.
module ysyx_22040750_refill_linebuf
  import ysyx_22040750_cache_refill_pkg::*;
#(
  parameter  int LINE_BYTES = 32,
  localparam int N  = LINE_BYTES / BEAT_BYTES,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic                    clr,
  input  logic                    beat,
  input  logic [CW-1:0]           limit,
  input  logic [63:0]             wdata,
  output logic                    acc,
  output logic [CW-1:0]           cnt,
  output logic                    over,
  output logic [LINE_BYTES*8-1:0] line
);
  logic [N-1:0][63:0] slots;

  assign acc  = beat && (cnt < limit);
  assign line = slots;

  // over remembers that at least one beat arrived past the limit, for the length check
  always_ff @(posedge I_clk) begin
    if (I_rst || clr) begin
      slots <= '0;
      cnt   <= '0;
      over  <= 1'b0;
    end else if (beat) begin
      if (acc) begin
        slots[cnt[IW-1:0]] <= wdata;
        cnt                <= cnt + CW'(1);
      end else begin
        over <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/ysyx_22040750_cache_refill.sv
// Cache refill / uncached-load engine: one AXI read burst per request, whole line returned at once.
// Optional macro REFILL_BEAT_FWD_EN adds per-beat forwarding ports for critical-word early restart.
module ysyx_22040750_cache_refill
  import ysyx_22040750_cache_refill_pkg::*;
#(
  parameter  int LINE_BYTES = 32,
  localparam int N    = LINE_BYTES / BEAT_BYTES,
  localparam int IW   = (N > 1) ? $clog2(N) : 1,
  localparam int OFFW = $clog2(LINE_BYTES)
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic                    I_req_valid,
  output logic                    O_req_ready,
  input  logic [31:0]             I_req_addr,
  input  logic                    I_req_uncached,
  input  logic [2:0]              I_req_size,
  output logic                    O_resp_valid,
  input  logic                    I_resp_ready,
  output logic [LINE_BYTES*8-1:0] O_resp_data,
  output logic                    O_resp_err,
  output logic [31:0]             O_araddr,
  output logic                    O_arvalid,
  input  logic                    I_arready,
  output logic [7:0]              O_arlen,
  output logic [2:0]              O_arsize,
  input  logic [63:0]             I_rdata,
  input  logic                    I_rvalid,
  input  logic                    I_rlast,
  output logic                    O_rready
`ifdef REFILL_BEAT_FWD_EN
  ,
  output logic                    O_beat_valid,
  output logic [IW-1:0]           O_beat_idx,
  output logic [63:0]             O_beat_data
`endif
);
  localparam int CW = $clog2(N + 1);

  logic [1:0]    state;
  ar_req_t       ar;
  logic          err;
  logic          clr, beat, acc, over;
  logic [CW-1:0] cnt, limit;

  assign clr   = (state == ST_IDLE) && I_req_valid;
  assign beat  = (state == ST_R) && I_rvalid;
  // uncached reads keep only slot 0, so the write limit is simply the burst length
  assign limit = CW'(ar.len) + CW'(1);

  ysyx_22040750_refill_linebuf #(.LINE_BYTES(LINE_BYTES)) u_linebuf (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .clr   (clr),
    .beat  (beat),
    .limit (limit),
    .wdata (I_rdata),
    .acc   (acc),
    .cnt   (cnt),
    .over  (over),
    .line  (O_resp_data)
  );

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state <= ST_IDLE;
      ar    <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (I_req_valid) begin
          ar.addr <= I_req_uncached ? I_req_addr : {I_req_addr[31:OFFW], {OFFW{1'b0}}};
          ar.len  <= I_req_uncached ? 8'd0 : 8'(N - 1);
          ar.size <= I_req_uncached ? I_req_size : AXI_SIZE_8B;
          err     <= 1'b0;
          state   <= ST_AR;
        end
        ST_AR: if (I_arready) state <= ST_R;
        // exactly limit beats iff this last beat fills the final slot and nothing overflowed
        ST_R: if (beat && I_rlast) begin
          err   <= !(acc && (cnt + CW'(1) == limit) && !over);
          state <= ST_DONE;
        end
        ST_DONE: if (I_resp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign O_req_ready  = (state == ST_IDLE);
  assign O_arvalid    = (state == ST_AR);
  assign O_rready     = (state == ST_R);
  assign O_resp_valid = (state == ST_DONE);
  assign O_resp_err   = err;
  assign O_araddr     = ar.addr;
  assign O_arlen      = ar.len;
  assign O_arsize     = ar.size;

`ifdef REFILL_BEAT_FWD_EN
  assign O_beat_valid = acc;
  assign O_beat_idx   = cnt[IW-1:0];
  assign O_beat_data  = I_rdata;
`endif
endmodule

// File: tb/tb_ysyx_22040750_cache_refill.sv
// Directed bench for the cache refill engine with a per-cycle line/AR model and literal pins.
module tb_ysyx_22040750_cache_refill;
  localparam int LB = 32;
  localparam int N  = LB / 8;
  localparam int W  = LB * 8;

  logic          clk = 0, rst = 1;
  logic          req_valid = 0, req_unc = 0, resp_ready = 0, arready = 0;
  logic          rvalid = 0, rlast = 0;
  logic [31:0]   req_addr = 0;
  logic [2:0]    req_size = 0;
  logic [63:0]   rdata = 0;
  logic          O_req_ready, O_resp_valid, O_resp_err, O_arvalid, O_rready;
  logic [W-1:0]  O_resp_data;
  logic [31:0]   O_araddr;
  logic [7:0]    O_arlen;
  logic [2:0]    O_arsize;

  ysyx_22040750_cache_refill #(.LINE_BYTES(LB)) dut (
    .I_clk(clk), .I_rst(rst),
    .I_req_valid(req_valid), .O_req_ready(O_req_ready), .I_req_addr(req_addr),
    .I_req_uncached(req_unc), .I_req_size(req_size),
    .O_resp_valid(O_resp_valid), .I_resp_ready(resp_ready),
    .O_resp_data(O_resp_data), .O_resp_err(O_resp_err),
    .O_araddr(O_araddr), .O_arvalid(O_arvalid), .I_arready(arready),
    .O_arlen(O_arlen), .O_arsize(O_arsize),
    .I_rdata(rdata), .I_rvalid(rvalid), .I_rlast(rlast), .O_rready(O_rready)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---- behavioural model: request + list of beats seen on the R channel ----
  logic         m_busy = 0, m_unc = 0;
  logic [31:0]  m_addr = 0;
  logic [2:0]   m_size = 0;
  logic [63:0]  mq[$];
  logic         pav = 0, par = 0, prv = 0, prr = 0;
  logic [42:0]  pa;
  logic [W:0]   pd;

  function automatic logic [W-1:0] exp_line();
    logic [W-1:0] r = '0;
    int lim = m_unc ? 1 : N;
    for (int k = 0; k < mq.size() && k < lim; k++) r[k*64 +: 64] = mq[k];
    return r;
  endfunction

  function automatic logic exp_err();
    return mq.size() != (m_unc ? 1 : N);
  endfunction

  always @(negedge clk) begin
    if (rst || cyc < 1) begin
      m_busy = 0; pav = 0; prv = 0;
    end else begin
      chk("req_ready", W'(O_req_ready), W'(!m_busy));
      if (O_arvalid) begin
        chk("araddr", W'(O_araddr), W'(m_unc ? m_addr : (m_addr & ~32'(LB - 1))));
        chk("arlen",  W'(O_arlen),  W'(m_unc ? 0 : N - 1));
        chk("arsize", W'(O_arsize), W'(m_unc ? m_size : 3'd3));
      end
      if (pav && !par)
        chk("ar_hold", W'({O_arvalid, O_araddr, O_arlen, O_arsize}), W'({1'b1, pa}));
      if (O_resp_valid) begin
        chk("resp_data", O_resp_data, exp_line());
        chk("resp_err",  W'(O_resp_err), W'(exp_err()));
      end
      if (prv && !prr)
        chk("resp_hold", W'({O_resp_valid, O_resp_err, O_resp_data}), W'({1'b1, pd}));
      pav = O_arvalid; par = arready; pa = {O_araddr, O_arlen, O_arsize};
      prv = O_resp_valid; prr = resp_ready; pd = {O_resp_err, O_resp_data};
      if (req_valid && O_req_ready) begin
        m_busy = 1; m_unc = req_unc; m_addr = req_addr; m_size = req_size; mq.delete();
      end
      if (rvalid && O_rready) mq.push_back(rdata);
      if (O_resp_valid && resp_ready) m_busy = 0;
    end
  end

  // ---- drivers ----
  logic [63:0] bd[8];

  task automatic do_req(input logic [31:0] a, input logic u, input logic [2:0] s);
    req_valid = 1; req_addr = a; req_unc = u; req_size = s;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic do_ar(input int delay);
    arready = 0;
    repeat (delay) begin @(posedge clk); #1; end
    arready = 1;
    @(posedge clk); #1;
    arready = 0;
  endtask

  task automatic send_beats(input int n, input bit gap, input bit with_last);
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        rvalid = 0; rlast = 0;
        @(posedge clk); #1;
      end
      rvalid = 1; rdata = bd[i]; rlast = with_last && (i == n - 1);
      @(posedge clk); #1;
    end
    rvalid = 0; rlast = 0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!O_resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!O_resp_valid) chk("resp_timeout", W'(O_resp_valid), W'(1));
  endtask

  task automatic finish_resp(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", W'(O_req_ready), W'(1));
    chk("rst_outs",  W'({O_arvalid, O_araddr, O_arlen, O_arsize, O_rready, O_resp_valid, O_resp_err}), '0);
    chk("rst_data",  O_resp_data, '0);
    rst = 0;
    @(posedge clk); #1;

    // aligned refill, back-to-back beats, latency pin
    bd[0] = 64'h11; bd[1] = 64'h22; bd[2] = 64'h33; bd[3] = 64'h44;
    do_req(32'h8000_0014, 0, 3'd0);
    t0 = cyc;
    chk("lit_araddr", W'(O_araddr), W'(32'h8000_0000));
    chk("lit_arlen",  W'(O_arlen),  W'(3));
    chk("lit_arsize", W'(O_arsize), W'(3));
    do_ar(0);
    send_beats(4, 0, 1);
    wait_resp();
    chk("lit_latency", W'(cyc - t0 + 1), W'(6));
    chk("lit_data", O_resp_data, {64'h44, 64'h33, 64'h22, 64'h11});
    chk("lit_err",  W'(O_resp_err), W'(0));
    finish_resp(0);

    // uncached single beat
    bd[0] = 64'h0000_0000_DEAD_BEEF;
    do_req(32'hA000_0004, 1, 3'd2);
    chk("unc_araddr", W'(O_araddr), W'(32'hA000_0004));
    chk("unc_arlen",  W'(O_arlen),  W'(0));
    chk("unc_arsize", W'(O_arsize), W'(2));
    do_ar(0);
    send_beats(1, 0, 1);
    wait_resp();
    chk("unc_data", O_resp_data, {192'h0, 64'h0000_0000_DEAD_BEEF});
    chk("unc_err",  W'(O_resp_err), W'(0));
    finish_resp(0);

    // AR stall: stability checked every cycle by the model process
    for (int i = 0; i < 4; i++) bd[i] = 64'h1000 + 64'(i);
    do_req(32'h8000_1238, 0, 3'd0);
    do_ar(5);
    send_beats(4, 0, 1);
    wait_resp();
    finish_resp(0);

    // R gaps plus response backpressure
    for (int i = 0; i < 4; i++) bd[i] = 64'hCAFE_0000_0000_0000 | 64'(i * 7 + 1);
    do_req(32'h8000_2000, 0, 3'd0);
    do_ar(1);
    send_beats(4, 1, 1);
    wait_resp();
    finish_resp(3);

    // short burst
    bd[0] = 64'hA1; bd[1] = 64'hA2;
    do_req(32'h8000_3000, 0, 3'd0);
    do_ar(0);
    send_beats(2, 0, 1);
    wait_resp();
    chk("short_data", O_resp_data, {128'h0, 64'hA2, 64'hA1});
    chk("short_err",  W'(O_resp_err), W'(1));
    finish_resp(0);

    // long burst: extra beats dropped
    for (int i = 0; i < 6; i++) bd[i] = 64'hB1 + 64'(i);
    do_req(32'h8000_4000, 0, 3'd0);
    do_ar(0);
    send_beats(6, 0, 1);
    wait_resp();
    chk("long_data", O_resp_data, {64'hB4, 64'hB3, 64'hB2, 64'hB1});
    chk("long_err",  W'(O_resp_err), W'(1));
    finish_resp(0);

    // reset in the middle of the R phase
    bd[0] = 64'hEE; bd[1] = 64'hFF;
    do_req(32'h8000_5000, 0, 3'd0);
    do_ar(0);
    send_beats(2, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_ready", W'(O_req_ready), W'(1));
    chk("mid_rst_outs",  W'({O_arvalid, O_araddr, O_arlen, O_arsize, O_rready, O_resp_valid, O_resp_err}), '0);
    chk("mid_rst_data",  O_resp_data, '0);
    rst = 0;
    for (int i = 0; i < 4; i++) bd[i] = 64'hC1 + 64'(i);
    do_req(32'h8000_6010, 0, 3'd0);
    do_ar(0);
    send_beats(4, 0, 1);
    wait_resp();
    chk("post_rst_data", O_resp_data, {64'hC4, 64'hC3, 64'hC2, 64'hC1});
    chk("post_rst_err",  W'(O_resp_err), W'(0));
    finish_resp(0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
